// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit seven-segment scan path.
// Contents:
//   N_DIGITS    number of multiplexed digits
//   IDX_W       width of a digit index
//   key_code_t  one keypad / decoder code
//   anode_t     active-low anode vector
//   ANODE_OFF   all digits blanked
//   anode_for() active-low one-hot enable for a digit index
package seg7_pkg;

    localparam int N_DIGITS = 4;
    localparam int IDX_W    = 2;

    typedef logic [3:0]          key_code_t;
    typedef logic [N_DIGITS-1:0] anode_t;
    typedef logic [IDX_W-1:0]    digit_idx_t;

    localparam anode_t ANODE_OFF = 4'b1111;

    // Active-low enable for one digit; digit 0 is the rightmost position.
    function automatic anode_t anode_for(input digit_idx_t idx);
        anode_t one_hot;
        one_hot = anode_t'(1) << idx;
        return ~one_hot;
    endfunction

endpackage

// File: rtl/refresh_tick_gen.sv
// Refresh timebase: counts 0..REFRESH_DIV-1 and pulses tick for one cycle
// while the counter sits at its terminal value (the same edge wraps it to 0).
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset, counter returns to 0
//   tick  one-cycle pulse every REFRESH_DIV cycles
module refresh_tick_gen #(
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = 20
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [CNT_W-1:0] cnt_q;

    assign tick = (cnt_q == CNT_W'(REFRESH_DIV - 1));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg7_scan_controller.sv
// Sequencer for a 4-digit multiplexed seven-segment display. Keeps the last
// four keypad codes in a shift buffer and presents one digit per refresh slot
// to the shared decoder, with the matching active-low anode.
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   key_valid   keypad "key held" level, one capture per rising edge
//   key_code    keypad code, stable while key_valid is high
//   clear       synchronous buffer clear (wins over a same-cycle capture)
//   digit_code  code for the active slot, to the decoder
//   anode       active-low digit enable, one-hot-low or all high
//   fill        number of populated digits, 0..4
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = 20
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      key_valid,
    input  key_code_t key_code,
    input  logic      clear,
    output key_code_t digit_code,
    output anode_t    anode,
    output logic [2:0] fill
);

    logic tick;

    refresh_tick_gen #(
        .REFRESH_DIV (REFRESH_DIV),
        .CNT_W       (CNT_W)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    key_code_t  d_q [N_DIGITS];
    key_code_t  d_d [N_DIGITS];
    logic [2:0] fill_q, fill_d;
    logic       key_valid_q;
    digit_idx_t scan_idx_q;
    key_code_t  digit_code_q;
    anode_t     anode_q;
    logic       capture;

    assign capture = key_valid && !key_valid_q;

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        d_d    = d_q;
        fill_d = fill_q;
        if (clear) begin
            for (int i = 0; i < N_DIGITS; i++) d_d[i] = '0;
            fill_d = '0;
        end else if (capture) begin
            // Newest code enters on the right; the oldest falls off the left.
            for (int i = N_DIGITS - 1; i > 0; i--) d_d[i] = d_q[i-1];
            d_d[0] = key_code;
            fill_d = (fill_q == 3'(N_DIGITS)) ? fill_q : fill_q + 3'd1;
        end
    end

    // NOTE: the digit buffer is a handful of flops, not a RAM, so it is reset
    // along with everything else; no stale digit can survive a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_DIGITS; i++) d_q[i] <= '0;
            fill_q       <= '0;
            key_valid_q  <= 1'b0;
            scan_idx_q   <= '0;
            digit_code_q <= '0;
            anode_q      <= ANODE_OFF;
        end else begin
            d_q         <= d_d;
            fill_q      <= fill_d;
            // Updates even under clear, so a key held through clear is not
            // seen as a fresh press afterwards.
            key_valid_q <= key_valid;
            if (tick) scan_idx_q <= scan_idx_q + digit_idx_t'(1);
            // Output stage reflects the pre-edge slot and buffer; both
            // outputs move together so code and anode never disagree.
            digit_code_q <= d_q[scan_idx_q];
            anode_q      <= ({1'b0, scan_idx_q} < fill_q) ? anode_for(scan_idx_q)
                                                           : ANODE_OFF;
        end
    end

    assign digit_code = digit_code_q;
    assign anode      = anode_q;
    assign fill       = fill_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Scoreboard bench for seg7_scan_controller with REFRESH_DIV=4. The driver
// applies one input vector per cycle, advances a behavioural model (a list
// of captured codes plus a cycle count since reset) and queues the outputs
// expected after that edge; a monitor pops and compares after each edge.
module tb_seg7_scan_controller;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       clear = 1'b0;
    logic [3:0] digit_code;
    logic [3:0] anode;
    logic [2:0] fill;

    seg7_scan_controller #(
        .REFRESH_DIV (DIV),
        .CNT_W       (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .clear      (clear),
        .digit_code (digit_code),
        .anode      (anode),
        .fill       (fill)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] dc;
        logic [3:0] an;
        logic [2:0] fl;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: codes newest-first, length is the fill level.
    int   m_buf[$];
    bit   m_prev_kv = 1'b0;
    int   m_cyc = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    // One clock: drive inputs, predict the outputs after the coming edge.
    task automatic cycle(input bit r, input bit kv, input logic [3:0] kc, input bit clr);
        exp_t e;
        int   slot;
        logic [3:0] one_hot;
        @(negedge clk);
        rst = r; key_valid = kv; key_code = kc; clear = clr;
        if (r) begin
            e.dc = 4'h0; e.an = 4'hF;
            m_buf.delete(); m_prev_kv = 1'b0; m_cyc = 0;
        end else begin
            slot = (m_cyc / DIV) % 4;
            if (slot < m_buf.size()) begin
                one_hot = 4'b0001 << slot;
                e.dc = 4'(m_buf[slot]);
                e.an = ~one_hot;
            end else begin
                e.dc = 4'h0; e.an = 4'hF;
            end
            if (clr) m_buf.delete();
            else if (kv && !m_prev_kv) begin
                m_buf.push_front(int'(kc));
                if (m_buf.size() > 4) void'(m_buf.pop_back());
            end
            m_prev_kv = kv;
            m_cyc++;
        end
        e.fl = 3'(m_buf.size());
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 4'h0, 0);
    endtask

    task automatic press(input logic [3:0] kc, input int hold);
        for (int i = 0; i < hold; i++) cycle(0, 1, kc, 0);
        cycle(0, 0, 4'h0, 0);
    endtask

    // Monitor: compare the DUT against the queued prediction after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("digit_code", {4'h0, digit_code}, {4'h0, e.dc});
                check("anode",      {4'h0, anode},      {4'h0, e.an});
                check("fill",       {5'h0, fill},       {5'h0, e.fl});
            end
        end
    end

    initial begin
        bit         kv;
        logic [3:0] kc;
        // Reset and idle scanning: everything stays blank.
        cycle(1, 0, 4'h0, 0);
        cycle(1, 0, 4'h0, 0);
        idle(40);
        // Long press of a single key yields one capture.
        press(4'h5, 10);
        idle(20);
        // Saturation: oldest digit drops out.
        press(4'h1, 3); idle(1);
        press(4'h2, 3); idle(1);
        press(4'h3, 3); idle(1);
        press(4'h4, 3); idle(1);
        press(4'h7, 3);
        idle(20);
        // Clear on the same edge as a key rising edge, key held afterwards.
        cycle(0, 1, 4'h9, 1);
        for (int i = 0; i < 6; i++) cycle(0, 1, 4'h9, 0);
        idle(8);
        press(4'h9, 2);
        idle(16);
        // Reset mid-slot with three digits shown.
        cycle(0, 0, 4'h0, 1);
        press(4'hA, 1); press(4'hB, 1); press(4'hC, 1);
        idle(2);
        cycle(1, 0, 4'h0, 0);
        idle(12);
        // Capture in the middle of slot 0 right after reset.
        cycle(1, 0, 4'h0, 0);
        idle(2);
        press(4'hE, 2);
        idle(20);
        // Randomised traffic.
        kv = 1'b0; kc = 4'h0;
        for (int i = 0; i < 2000; i++) begin
            if (kv) begin
                if ($urandom_range(3) == 0) kv = 1'b0;
            end else if ($urandom_range(2) == 0) begin
                kv = 1'b1;
                kc = 4'($urandom_range(15));
            end
            cycle(($urandom_range(149) == 0), kv, kc, ($urandom_range(24) == 0));
        end
        idle(2);
        @(negedge clk);
        check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg7_scan_controller.md
Name: seg7_scan_controller

Overview:
Sequencer for the 4-digit multiplexed seven-segment display.
- Holds the last four keypad codes in a shift buffer.
- Time-multiplexes them onto the shared combinational digit decoder (`seg7_control`), one digit per refresh slot.
- Drives the matching active-low anode.
- Sits between the keypad scanner (`key_valid`/`key_code`) and the decoder's `dec` input.

Parameters:
- REFRESH_DIV, 50000: clock cycles per digit slot (100 MHz gives 2 kHz per slot, 500 Hz full frame); legal range 2 to 2^20.
- CNT_W, 20: width of the refresh counter; must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- key_valid  input  1  keypad "key held" level; one capture per 0->1 transition.
- key_code  input  4  keypad code, stable whenever key_valid=1.
- clear  input  1  synchronous buffer clear, single-cycle or level.
- digit_code  output  4  code for the active slot, to decoder `dec`.
- anode  output  4  active-low digit enable, one-hot-low or all high.
- fill  output  3  number of populated digits, 0..4.

Behaviour:
- Reset (rst=1 at a clk edge), required values:
  - anode=4'b1111, digit_code=4'h0, fill=0.
  - Digit buffer all 4'h0, scan_idx=0, refresh counter=0, key_valid_q=0.
  - Reset mid-frame or mid-capture discards everything; no partial state survives.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1 it wraps to 0 and emits a 1-cycle tick.
  - On tick, scan_idx <= scan_idx+1 (2-bit, wraps 3->0).
- Key capture:
  - key_valid_q registers key_valid; a capture occurs when key_valid=1 and key_valid_q=0.
  - On capture, shift: d[3]<=d[2], d[2]<=d[1], d[1]<=d[0], d[0]<=key_code.
  - fill <= min(fill+1, 4). At fill=4 the oldest digit d[3] is dropped and fill stays 4.
  - A held key produces exactly one capture. Release and re-press produces a new capture.
- Clear:
  - clear=1 sets d[*]=0 and fill=0 the next edge.
  - clear has priority over a same-cycle capture; that key is lost.
  - key_valid_q still updates, so a key held through clear is not re-captured.
- Output stage (registered, one cycle after scan_idx / buffer state):
  - digit_code <= d[scan_idx].
  - anode <= ~(4'b0001 << scan_idx) if scan_idx < fill, else 4'b1111 (unpopulated slots blank).
  - digit_code and anode always update on the same edge, so they never mismatch.
- A capture during a slot shows up in the outputs on the next clock; slot timing is unaffected.
- Digit position: d[0] is rightmost, driven by anode[0].
- fill is a registered output.

Decomposition:
- seg7_pkg:
  - N_DIGITS=4.
  - typedef logic [3:0] key_code_t.
  - typedef logic [N_DIGITS-1:0] anode_t.
  - ANODE_OFF=4'b1111.
- Sub-module refresh_tick_gen: parameters REFRESH_DIV and CNT_W; ports clk, rst, tick.
- The top instantiates refresh_tick_gen and holds the buffer, edge detect and output stage. The decoder is instantiated by the parent, not here.

Test Plan (REFRESH_DIV=4 in simulation):
- Reset, then 40 idle cycles -> anode stays 4'b1111, digit_code=0, fill=0; a tick every 4 cycles; scan_idx cycles 0,1,2,3,0.
- Press 4'h5 (key_valid high 10 cycles), release -> exactly one capture, fill=1; anode[0] low only during slot 0 with digit_code=5; other slots 1111.
- Press 1,2,3,4,7 in order -> fill saturates at 4; d[3..0]=2,3,4,7; slots 0..3 show 7,4,3,2 with anode 1110,1101,1011,0111.
- clear and a key_valid rising edge in the same cycle -> fill=0, all digits 0, anode 1111; key still held afterwards -> no capture until release and re-press.
- Assert rst for 1 cycle mid-slot with fill=3 -> next cycle all outputs at reset values; counter restarts at 0 (next tick 4 cycles later).
- Capture at counter=2 of slot 0 -> slot 1 still starts exactly at the next tick; new d[0] visible on digit_code the next time scan_idx=0.
